// File: rtl/cdc_bus_src_ctrl.sv
// Source-side controller for a four-phase bus synchronizer: stream in, cur/pend staging, req/ack handshake.
// Optional handshake watchdog compiled in with `define CDC_SRC_WATCHDOG_EN.
module cdc_bus_src_ctrl #(
    parameter int unsigned C_WIDTH          = 8,
    parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [C_WIDTH-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [C_WIDTH-1:0] src_in,
    output logic               src_req,
    input  logic               src_ack,
    output logic               busy,
    output logic [15:0]        xfer_cnt,
    output logic               timeout_err,
    input  logic               err_clr
);

    localparam logic [15:0] LP_TIMEOUT = 16'(C_TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_WIDTH-1:0] r_cur;
    logic [C_WIDTH-1:0] w_cur_nxt;
    logic [C_WIDTH-1:0] r_pend;
    logic [C_WIDTH-1:0] w_pend_nxt;
    logic               r_pend_vld;
    logic               w_pend_vld_nxt;
    logic               r_src_req;
    logic               w_src_req_nxt;
    logic [15:0]        r_xfer_cnt;
    logic               w_accept;
    logic               w_done;

    assign s_ready  = !r_pend_vld && !rst;
    assign w_accept = s_valid && s_ready;
    assign busy     = (r_state != ST_IDLE) || r_pend_vld;
    assign src_in   = r_cur;
    assign src_req  = r_src_req;
    assign xfer_cnt = r_xfer_cnt;

    // Next-state and staging logic; w_done marks the REL exit edge (handshake complete).
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_nxt      = r_cur;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_src_req_nxt  = r_src_req;
        w_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cur_nxt     = s_data;
                    w_src_req_nxt = 1'b1;
                    w_state_nxt   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_accept) begin
                    w_pend_nxt     = s_data;
                    w_pend_vld_nxt = 1'b1;
                end
                if (src_ack) begin
                    w_src_req_nxt = 1'b0;
                    w_state_nxt   = ST_REL;
                end
            end
            ST_REL: begin
                if (src_ack) begin
                    if (w_accept) begin
                        w_pend_nxt     = s_data;
                        w_pend_vld_nxt = 1'b1;
                    end
                end else begin
                    w_done = 1'b1;
                    if (r_pend_vld) begin
                        w_cur_nxt      = r_pend;
                        w_pend_vld_nxt = 1'b0;
                        w_src_req_nxt  = 1'b1;
                        w_state_nxt    = ST_REQ;
                    end else if (s_valid) begin
                        w_cur_nxt     = s_data;
                        w_src_req_nxt = 1'b1;
                        w_state_nxt   = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_src_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cur      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_src_req  <= 1'b0;
            r_xfer_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_src_req  <= w_src_req_nxt;
            if (w_done) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
        end
    end

`ifdef CDC_SRC_WATCHDOG_EN
    logic [15:0] r_wdog;
    logic        r_timeout_err;
    logic        w_wd_hit;

    // Fires once, on the edge where the count reaches the limit; the handshake itself keeps running.
    assign w_wd_hit    = (r_state != ST_IDLE) && (w_state_nxt == r_state) && (r_wdog == LP_TIMEOUT - 16'd1);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog        <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wdog <= 16'd0;
            end else if ((r_state != ST_IDLE) && (r_wdog != LP_TIMEOUT)) begin
                r_wdog <= r_wdog + 16'd1;
            end
            if (w_wd_hit) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end
`else
    logic w_unused;

    assign timeout_err = 1'b0;
    assign w_unused    = ^{err_clr, LP_TIMEOUT};
`endif

endmodule

// File: doc/cdc_bus_src_ctrl.md
CDC_BUS_SRC_CTRL -- requirements
Module: cdc_bus_src_ctrl

Interface
REQ-001 Parameter C_WIDTH, default 8, SHALL set the data width of s_data and src_in.
REQ-002 Parameter C_TIMEOUT_CYCLES, default 1024, range 2-65535, SHALL set the handshake watchdog limit in clk cycles.
REQ-003 clk  in  1  SHALL be the single clock of the block. It is the source-domain clock of the bus synchronizer.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 s_data  in  C_WIDTH  SHALL carry the upstream stream payload.
REQ-006 s_valid  in  1  SHALL mark s_data as valid.
REQ-007 s_ready  out  1  SHALL mark the block as able to accept a word.
REQ-008 src_in  out  C_WIDTH  SHALL be the registered payload driven to the synchronizer source bus.
REQ-009 src_req  out  1  SHALL be the registered synchronizer send request.
REQ-010 src_ack  in  1  SHALL be the synchronizer receive acknowledge, already in the clk domain.
REQ-011 busy  out  1  SHALL be high while a word is held or a handshake is open.
REQ-012 xfer_cnt  out  16  SHALL count completed transfers.
REQ-013 timeout_err  out  1  SHALL be a sticky watchdog error flag.
REQ-014 err_clr  in  1  SHALL clear timeout_err.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ and REL; storage SHALL be one current register (cur, drives src_in) and one pending register (pend, with pend_vld).
REQ-016 s_ready SHALL equal !pend_vld && !rst; a word SHALL be accepted on a clk edge where s_valid && s_ready.
REQ-017 IDLE with an accept: cur<=s_data, go to REQ, src_req=1; src_req SHALL be visible exactly 1 cycle after the accept edge.
REQ-018 REQ: src_req SHALL stay 1 until src_ack==1 is sampled; on that edge src_req<=0 and the FSM SHALL go to REL.
REQ-019 REL: the FSM SHALL wait for src_ack==0; on that edge xfer_cnt SHALL increment.
REQ-020 REL exit: if pend_vld, cur<=pend, pend_vld<=0, go to REQ with src_req<=1; else if s_valid (simultaneous accept), cur<=s_data, go to REQ; else go to IDLE.
REQ-021 An accept while in REQ or REL SHALL load pend and set pend_vld.
REQ-022 src_in SHALL be stable from src_req rise until the REL exit edge.
REQ-023 src_ack==1 sampled in IDLE SHALL be ignored, with no state or output change.
REQ-024 xfer_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-025 busy SHALL equal (state!=IDLE) || pend_vld.
REQ-026 Back-to-back throughput SHALL be one word per full four-phase handshake, with no idle cycle between REL exit and the next src_req rise.

Reset
REQ-027 While rst is high: state=IDLE, src_req=0, src_in=0, pend_vld=0, xfer_cnt=0, timeout_err=0, watchdog=0, s_ready=0, busy=0.
REQ-028 Reset asserted mid-handshake SHALL discard cur and pend immediately, with no completion counted; the first accept SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-029 Macro CDC_SRC_WATCHDOG_EN, when defined, SHALL compile in a 16-bit watchdog: it counts cycles spent in REQ or REL and clears on any state change.
REQ-030 With CDC_SRC_WATCHDOG_EN defined, the watchdog reaching C_TIMEOUT_CYCLES SHALL set timeout_err on the next cycle and saturate. The handshake SHALL NOT be aborted.
REQ-031 With CDC_SRC_WATCHDOG_EN defined, err_clr=1 SHALL clear timeout_err, and set SHALL win over a same-cycle err_clr.
REQ-032 Without CDC_SRC_WATCHDOG_EN: no watchdog logic, timeout_err tied to 0, err_clr ignored.

Verification
REQ-033 Single word: s_data=0xA5, ack rises 4 cycles after src_req and falls 4 cycles after src_req falls -> src_in=0xA5, src_req 1 cycle after accept, xfer_cnt=1, busy=0 at end.
REQ-034 Burst of 3 words 0x01,0x02,0x03 with s_valid held high -> s_ready low after 2nd accept until 1st REL exit, src_in sequence 0x01,0x02,0x03, xfer_cnt=3, no idle cycle between handshakes.
REQ-035 Spurious src_ack=1 in IDLE for 2 cycles -> src_req stays 0, xfer_cnt unchanged.
REQ-036 rst pulsed while in REL with pend holding 0x55 -> src_req=0, pend_vld=0, xfer_cnt=0; next word 0x66 -> src_in=0x66.
REQ-037 xfer_cnt preloaded to 0xFFFF via 65535 transfers, then one more -> xfer_cnt=0x0000.
REQ-038 CDC_SRC_WATCHDOG_EN defined, C_TIMEOUT_CYCLES=16, src_ack held 0 -> timeout_err=1 at cycle 17 of REQ; err_clr -> 0; late ack completes normally, xfer_cnt=1.
